steer_en_gen: RTL and testbench



---
 rtl/steer_en_gen.sv | 168 ++++++++++++++++
 tb/tb_steer_en_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/steer_en_gen.sv
// steer_en_gen: rider-presence detection and steering-enable generation.
// Decides from the two load-cell readings whether a rider is on the platform
// and whether the load is balanced well enough to hand steering to the
// balance controller. Outputs are decoded from registered state only.
module steer_en_gen #(
  parameter int unsigned LD_W         = 12,
  parameter int unsigned MIN_RIDER_WT = 'h200,
  parameter int unsigned WT_HYST      = 'h40,
  parameter int unsigned EN_SHIFT     = 2,
  parameter int unsigned DIS_SHIFT    = 4,
  parameter int unsigned TMR_W        = 26,
  parameter int unsigned TMR_LIM      = 'h3FE56C0,
  parameter bit          FAST_SIM     = 1'b1,
  parameter int unsigned TMR_SIM      = 'h7FFF,
  parameter int unsigned OFF_CNT      = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [LD_W-1:0] lft_ld,
  input  logic signed [LD_W-1:0] rght_ld,
  output logic                   en_steer,
  output logic                   rider_off,
  output logic [1:0]             steer_state
);

  // Clamped loads are non-negative, so the sign bit is dropped.
  localparam int unsigned UW = LD_W - 1;

  localparam int unsigned ThrLo = MIN_RIDER_WT - WT_HYST;
  localparam int unsigned ThrHi = MIN_RIDER_WT + WT_HYST;

  localparam logic [TMR_W-1:0] Lim = FAST_SIM ? TMR_W'(TMR_SIM) : TMR_W'(TMR_LIM);

  localparam logic [7:0] OffMax   = 8'(OFF_CNT);
  localparam logic [7:0] OffLeave = 8'(OFF_CNT - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StWait  = 2'b01,
    StSteer = 2'b10
  } state_e;

  state_e state_q, state_d;

  logic [UW-1:0]    lc, rc;
  logic [UW-1:0]    abs_diff;
  logic [LD_W-1:0]  sum;
  logic [LD_W-1:0]  diff_ext;
  logic [31:0]      sum_ext;
  logic             sum_lt_min, sum_gt_min;
  logic             diff_gt_en, diff_gt_dis;

  logic [7:0]       off_cnt_q, off_cnt_d;
  logic             rider_leave;

  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic             tmr_full;
  logic             clr_tmr;

  // Clamp negative readings to zero and form sum / absolute difference.
  always_comb begin
    lc       = lft_ld[LD_W-1]  ? '0 : lft_ld[UW-1:0];
    rc       = rght_ld[LD_W-1] ? '0 : rght_ld[UW-1:0];
    sum      = {1'b0, lc} + {1'b0, rc};
    abs_diff = (lc >= rc) ? (lc - rc) : (rc - lc);
    diff_ext = {1'b0, abs_diff};
    sum_ext  = 32'(sum);
  end

  // Weight and balance comparisons, all unsigned.
  always_comb begin
    sum_lt_min  = sum_ext < ThrLo;
    sum_gt_min  = sum_ext > ThrHi;
    diff_gt_en  = diff_ext > (sum >> EN_SHIFT);
    diff_gt_dis = diff_ext > (sum - (sum >> DIS_SHIFT));
  end

  // Debounce counter: counts consecutive light cycles, saturating.
  always_comb begin
    off_cnt_d = off_cnt_q;
    if (!sum_lt_min) begin
      off_cnt_d = '0;
    end else if (off_cnt_q < OffMax) begin
      off_cnt_d = off_cnt_q + 8'd1;
    end
    rider_leave = sum_lt_min && (off_cnt_q >= OffLeave);
  end

  // Debounce counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      off_cnt_q <= '0;
    end else begin
      off_cnt_q <= off_cnt_d;
    end
  end

  // Settle timer: runs only in WAIT and holds at the limit instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_tmr) begin
      cnt_d = '0;
    end else if ((state_q == StWait) && (cnt_q != Lim)) begin
      cnt_d = cnt_q + 1'b1;
    end
    tmr_full = (cnt_q == Lim);
  end

  // Settle timer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; rider_leave is checked first so it wins over timer/balance.
  always_comb begin
    state_d = state_q;
    clr_tmr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sum_gt_min) begin
          state_d = StWait;
          clr_tmr = 1'b1;
        end
      end
      StWait: begin
        if (rider_leave) begin
          state_d = StIdle;
        end else if (diff_gt_en) begin
          clr_tmr = 1'b1;
        end else if (tmr_full) begin
          state_d = StSteer;
        end
      end
      StSteer: begin
        if (rider_leave) begin
          state_d = StIdle;
        end else if (diff_gt_dis) begin
          state_d = StWait;
          clr_tmr = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from registered state only, so they cannot glitch.
  always_comb begin
    en_steer    = (state_q == StSteer);
    rider_off   = (state_q == StIdle);
    steer_state = state_q;
  end

endmodule

// File: tb/tb_steer_en_gen.sv
// Randomised scoreboard bench for steer_en_gen with a behavioural model.
module tb_steer_en_gen;

  localparam int LD_W    = 12;
  localparam int TMR_SIM = 15;
  localparam int OFF_CNT = 4;
  localparam int THR_LO  = 'h200 - 'h40;
  localparam int THR_HI  = 'h200 + 'h40;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic signed [LD_W-1:0] lft_ld = '0;
  logic signed [LD_W-1:0] rght_ld = '0;
  logic                   en_steer;
  logic                   rider_off;
  logic [1:0]             steer_state;

  steer_en_gen #(
    .TMR_SIM (TMR_SIM),
    .OFF_CNT (OFF_CNT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .lft_ld      (lft_ld),
    .rght_ld     (rght_ld),
    .en_steer    (en_steer),
    .rider_off   (rider_off),
    .steer_state (steer_state)
  );

  always #5 clk = ~clk;

  // Expected {en_steer, rider_off, steer_state} after each edge.
  logic [3:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 0 = idle, 1 = waiting to settle, 2 = steering.
  int m_state = 0;
  int m_wait  = 0;
  int m_low   = 0;

  task automatic model_step(input int l, input int r, input bit rs);
    int lc, rc, sum, dif, nxt;
    bit leave, restart;
    if (rs) begin
      m_state = 0;
      m_wait  = 0;
      m_low   = 0;
    end else begin
      lc      = (l < 0) ? 0 : l;
      rc      = (r < 0) ? 0 : r;
      sum     = lc + rc;
      dif     = (lc > rc) ? lc - rc : rc - lc;
      leave   = (sum < THR_LO) && (m_low + 1 >= OFF_CNT);
      restart = 1'b0;
      nxt     = m_state;
      if (m_state == 0) begin
        if (sum > THR_HI) begin
          nxt = 1;
          restart = 1'b1;
        end
      end else if (m_state == 1) begin
        if (leave) nxt = 0;
        else if (dif > sum / 4) restart = 1'b1;
        else if (m_wait == TMR_SIM) nxt = 2;
      end else begin
        if (leave) nxt = 0;
        else if (dif > sum - sum / 16) begin
          nxt = 1;
          restart = 1'b1;
        end
      end
      if (restart) m_wait = 0;
      else if (m_state == 1 && m_wait < TMR_SIM) m_wait = m_wait + 1;
      if (sum < THR_LO) m_low = (m_low < OFF_CNT) ? m_low + 1 : OFF_CNT;
      else m_low = 0;
      m_state = nxt;
    end
  endtask

  task automatic step(input int l, input int r, input bit rs);
    logic [1:0] sc;
    @(negedge clk);
    lft_ld  = l[LD_W-1:0];
    rght_ld = r[LD_W-1:0];
    rst     = rs;
    model_step(l, r, rs);
    sc = m_state[1:0];
    exp_q.push_back({(m_state == 2), (m_state == 0), sc});
  endtask

  task automatic hold(input int l, input int r, input int n);
    for (int i = 0; i < n; i++) step(l, r, 1'b0);
  endtask

  // Monitor: compares each post-edge output against the queued expectation.
  initial begin
    logic [3:0] exp;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        n_checks++;
        if ({en_steer, rider_off, steer_state} !== exp) begin
          n_fail++;
          $display("FAIL outputs @%0t: got en=%b off=%b st=%b, expected en=%b off=%b st=%b",
                   $time, en_steer, rider_off, steer_state, exp[3], exp[2], exp[1:0]);
        end
      end
    end
  end

  initial begin
    int mode, base, l, r;
    // Reset with arbitrary loads, then one quiet cycle after release.
    for (int i = 0; i < 3; i++) step(int'($urandom_range(0, 4095)) - 2048, 'h300, 1'b1);
    hold(0, 0, 1);
    // Mount; imbalance on cycle 10 of WAIT, then settle into STEER.
    hold('h150, 'h150, 10);
    hold('h200, 'h0A0, 1);
    hold('h150, 'h150, 20);
    // Extreme imbalance drops to WAIT; moderate imbalance keeps timer cleared.
    hold('h2A0, 'h000, 1);
    hold('h280, 'h020, 20);
    hold('h150, 'h150, 20);
    // Short light dip is debounced; a long one declares the rider off.
    hold('h100, -'h050, 3);
    hold('h150, 'h150, 1);
    hold('h100, -'h050, 4);
    // Reset while steering, then remount.
    hold('h150, 'h150, 20);
    step('h150, 'h150, 1'b1);
    hold('h150, 'h150, 20);
    // Randomised phases.
    for (int k = 0; k < 180; k++) begin
      mode = int'($urandom_range(0, 9));
      if ($urandom_range(0, 30) == 0) step('h150, 'h150, 1'b1);
      for (int c = 0; c < int'($urandom_range(1, 25)); c++) begin
        base = int'($urandom_range('h120, 'h300));
        case (mode)
          0, 1, 2, 3: begin
            l = base + int'($urandom_range(0, 40)) - 20;
            r = base + int'($urandom_range(0, 40)) - 20;
          end
          4: begin
            l = int'($urandom_range(0, 'hF0));
            r = int'($urandom_range(0, 'hF0));
          end
          5: begin
            l = -int'($urandom_range(0, 2048));
            r = int'($urandom_range(0, 'h300));
          end
          6: begin
            l = base;
            r = base / 3;
          end
          7: begin
            l = base * 2;
            r = int'($urandom_range(0, 'h20));
          end
          8: begin
            l = int'($urandom_range('hE0, 'h120));
            r = int'($urandom_range('hE0, 'h120));
          end
          default: begin
            l = int'($urandom_range(0, 4095)) - 2048;
            r = int'($urandom_range(0, 4095)) - 2048;
          end
        endcase
        step(l, r, 1'b0);
      end
    end
    @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
